// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - token codes and buffer FSM state encoding shared by the calculator blocks
package calc_pkg;

  localparam logic [7:0] OP_0       = 8'h00;
  localparam logic [7:0] OP_1       = 8'h01;
  localparam logic [7:0] OP_2       = 8'h02;
  localparam logic [7:0] OP_3       = 8'h03;
  localparam logic [7:0] OP_4       = 8'h04;
  localparam logic [7:0] OP_5       = 8'h05;
  localparam logic [7:0] OP_6       = 8'h06;
  localparam logic [7:0] OP_7       = 8'h07;
  localparam logic [7:0] OP_8       = 8'h08;
  localparam logic [7:0] OP_9       = 8'h09;
  localparam logic [7:0] OP_ADD     = 8'h0A;
  localparam logic [7:0] OP_SUB     = 8'h0B;
  localparam logic [7:0] OP_MUL     = 8'h0C;
  localparam logic [7:0] OP_DIV     = 8'h0D;
  localparam logic [7:0] OP_POW     = 8'h0E;
  localparam logic [7:0] OP_LPAREN  = 8'h0F;
  localparam logic [7:0] OP_RPAREN  = 8'h10;
  localparam logic [7:0] OP_SIN     = 8'h11;
  localparam logic [7:0] OP_COS     = 8'h12;
  localparam logic [7:0] OP_TAN     = 8'h13;
  localparam logic [7:0] OP_DECIMAL = 8'h14;
  localparam logic [7:0] OP_E       = 8'h15;
  localparam logic [7:0] OP_PI      = 8'h16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INS_SHIFT = 2'd1,
    DEL_SHIFT = 2'd2,
    STREAM    = 2'd3
  } state_t;

endpackage

// File: rtl/expr_buffer_if.sv
// rtl/expr_buffer_if.sv - token stream from the expression buffer to the evaluator
interface expr_buffer_if #(
  parameter int width = 8
);
  logic [width-1:0] tok_data;
  logic             tok_valid;
  logic             tok_ready;
  logic             tok_last;

  modport master (output tok_data, output tok_valid, output tok_last, input tok_ready);
  modport slave  (input tok_data, input tok_valid, input tok_last, output tok_ready);
endinterface

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector for a level-held keyboard control
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);
  logic prev;
  logic primed;

  // primed keeps a level held through reset release from looking like an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev   <= 1'b0;
      primed <= 1'b0;
    end else begin
      prev   <= level;
      primed <= 1'b1;
    end
  end

  assign rise = level & ~prev & primed;
endmodule

// File: rtl/expr_buffer.sv
// rtl/expr_buffer.sv - keyboard-edited token buffer streamed to the evaluator; EXPR_BUFFER_CLEAR_ON_EVAL_EN empties it after eval
module expr_buffer
  import calc_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [width-1:0]         dataIn,
  input  logic                     insert,
  input  logic                     del,
  input  logic                     ptrLeft,
  input  logic                     ptrRight,
  input  logic                     eval,
  expr_buffer_if.master            tok,
  output logic                     eval_done,
  input  logic [$clog2(depth)-1:0] disp_addr,
  output logic [width-1:0]         disp_data,
  output logic [$clog2(depth):0]   size,
  output logic [$clog2(depth):0]   cursor,
  output logic                     busy,
  output logic                     full,
  output logic                     overflow
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_count = (aw+1)'(depth);
`ifdef EXPR_BUFFER_CLEAR_ON_EVAL_EN
  localparam bit clear_on_eval = 1'b1;
`else
  localparam bit clear_on_eval = 1'b0;
`endif

  logic [width-1:0] mem [depth];
  state_t           state, state_n;
  logic [aw:0]      size_n, cursor_n, idx, idx_n, idx_p1;
  logic [aw-1:0]    idx_a, mem_wa;
  logic [width-1:0] data_q, data_n, mem_wd;
  logic             mem_we, eval_done_n, overflow_n, last;
  logic             ins_rise, del_rise, left_rise, right_rise, eval_rise;

  edge_detect u_ins   (.clock(clock), .reset(reset), .level(insert),   .rise(ins_rise));
  edge_detect u_del   (.clock(clock), .reset(reset), .level(del),      .rise(del_rise));
  edge_detect u_left  (.clock(clock), .reset(reset), .level(ptrLeft),  .rise(left_rise));
  edge_detect u_right (.clock(clock), .reset(reset), .level(ptrRight), .rise(right_rise));
  edge_detect u_eval  (.clock(clock), .reset(reset), .level(eval),     .rise(eval_rise));

  assign idx_a         = idx[aw-1:0];
  assign idx_p1        = idx + 1'b1;
  assign last          = (idx_p1 == size);
  assign busy          = (state != IDLE);
  assign full          = (size == full_count);
  assign tok.tok_valid = (state == STREAM);
  assign tok.tok_last  = (state == STREAM) && last;
  assign tok.tok_data  = mem[idx_a];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      size      <= '0;
      cursor    <= '0;
      idx       <= '0;
      data_q    <= '0;
      eval_done <= 1'b0;
      overflow  <= 1'b0;
      disp_data <= '0;
    end else begin
      state     <= state_n;
      size      <= size_n;
      cursor    <= cursor_n;
      idx       <= idx_n;
      data_q    <= data_n;
      eval_done <= eval_done_n;
      overflow  <= overflow_n;
      disp_data <= mem[disp_addr];
    end
  end

  // write strobe is derived from state, so an asserted reset forces it low at once
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    state_n     = state;
    size_n      = size;
    cursor_n    = cursor;
    idx_n       = idx;
    data_n      = data_q;
    eval_done_n = 1'b0;
    overflow_n  = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = idx_a;
    mem_wd      = data_q;
    unique case (state)
      IDLE: begin
        if (ins_rise) begin
          if (full) begin
            overflow_n = 1'b1;
          end else begin
            data_n  = dataIn;
            idx_n   = size;
            state_n = INS_SHIFT;
          end
        end else if (del_rise) begin
          if (cursor != '0) begin
            idx_n   = cursor - 1'b1;
            state_n = DEL_SHIFT;
          end
        end else if (left_rise) begin
          if (cursor != '0) cursor_n = cursor - 1'b1;
        end else if (right_rise) begin
          if (cursor != size) cursor_n = cursor + 1'b1;
        end else if (eval_rise) begin
          if (size != '0) begin
            idx_n   = '0;
            state_n = STREAM;
          end else begin
            eval_done_n = 1'b1;
          end
        end
      end
      INS_SHIFT: begin
        mem_we = 1'b1;
        if (idx > cursor) begin
          mem_wd = mem[idx_a - 1'b1];
          idx_n  = idx - 1'b1;
        end else begin
          mem_wa   = cursor[aw-1:0];
          size_n   = size + 1'b1;
          cursor_n = cursor + 1'b1;
          state_n  = IDLE;
        end
      end
      DEL_SHIFT: begin
        if (idx_p1 < size) begin
          mem_we = 1'b1;
          mem_wd = mem[idx_p1[aw-1:0]];
          idx_n  = idx_p1;
        end else begin
          size_n   = size - 1'b1;
          cursor_n = cursor - 1'b1;
          state_n  = IDLE;
        end
      end
      STREAM: begin
        if (tok.tok_ready) begin
          if (last) begin
            eval_done_n = 1'b1;
            state_n     = IDLE;
            if (clear_on_eval) begin
              size_n   = '0;
              cursor_n = '0;
            end
          end else begin
            idx_n = idx_p1;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_expr_buffer.sv
// tb/tb_expr_buffer.sv - directed self-checking bench for expr_buffer
module tb_expr_buffer;
  import calc_pkg::*;

  localparam int width = 8;
  localparam int depth = 32;
`ifdef EXPR_BUFFER_CLEAR_ON_EVAL_EN
  localparam bit clr = 1'b1;
`else
  localparam bit clr = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dataIn = '0;
  logic       insert = 1'b0, del = 1'b0, ptrLeft = 1'b0, ptrRight = 1'b0, eval = 1'b0;
  logic       eval_done, busy, full, overflow;
  logic [4:0] disp_addr = '0;
  logic [7:0] disp_data;
  logic [5:0] size, cursor;
  int         checks = 0;
  int         errors = 0;

  expr_buffer_if #(.width(width)) tok_if ();

  expr_buffer #(.width(width), .depth(depth)) dut (
    .clock(clock), .reset(reset), .dataIn(dataIn),
    .insert(insert), .del(del), .ptrLeft(ptrLeft), .ptrRight(ptrRight), .eval(eval),
    .tok(tok_if), .eval_done(eval_done), .disp_addr(disp_addr), .disp_data(disp_data),
    .size(size), .cursor(cursor), .busy(busy), .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    repeat (2) tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic do_insert(input logic [7:0] d);
    dataIn = d;
    insert = 1'b1;
    tick;
    insert = 1'b0;
    tick;
    wait_idle;
  endtask

  task automatic press_left;
    ptrLeft = 1'b1;
    tick;
    ptrLeft = 1'b0;
    tick;
  endtask

  task automatic press_right;
    ptrRight = 1'b1;
    tick;
    ptrRight = 1'b0;
    tick;
  endtask

  task automatic press_del;
    del = 1'b1;
    tick;
    del = 1'b0;
    tick;
    wait_idle;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick;
    checks++;
    if (size !== 6'd0 || cursor !== 6'd0 || busy !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state size=%0d cursor=%0d busy=%0b full=%0b, required 0 0 0 0", size, cursor, busy, full);
    end
    checks++;
    if (tok_if.tok_valid !== 1'b0 || tok_if.tok_last !== 1'b0 || eval_done !== 1'b0 || overflow !== 1'b0 || disp_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs valid=%0b last=%0b done=%0b ovf=%0b disp=%02h, required all 0",
               tok_if.tok_valid, tok_if.tok_last, eval_done, overflow, disp_data);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_insert_stream;
    logic [7:0] exp_tok [3];
    logic       exp_last;
    exp_tok[0] = OP_1;
    exp_tok[1] = OP_ADD;
    exp_tok[2] = OP_2;
    apply_reset;
    for (int i = 0; i < 3; i++) do_insert(exp_tok[i]);
    checks++;
    if (size !== 6'd3 || cursor !== 6'd3) begin
      errors++;
      $display("FAIL append3 size=%0d cursor=%0d, required 3 3", size, cursor);
    end
    eval = 1'b1;
    tick;
    eval = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_last = (i == 2);
      checks++;
      if (tok_if.tok_valid !== 1'b1 || tok_if.tok_data !== exp_tok[i] || tok_if.tok_last !== exp_last) begin
        errors++;
        $display("FAIL stream_tok%0d valid=%0b data=%02h last=%0b, required 1 %02h %0b",
                 i, tok_if.tok_valid, tok_if.tok_data, tok_if.tok_last, exp_tok[i], exp_last);
      end
      tick;
    end
    checks++;
    if (eval_done !== 1'b1 || tok_if.tok_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_done done=%0b valid=%0b busy=%0b, required 1 0 0", eval_done, tok_if.tok_valid, busy);
    end
    checks++;
    if (size !== (clr ? 6'd0 : 6'd3) || cursor !== (clr ? 6'd0 : 6'd3)) begin
      errors++;
      $display("FAIL stream_size size=%0d cursor=%0d, required %0d", size, cursor, clr ? 0 : 3);
    end
    tick;
    checks++;
    if (eval_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%0b, required 0", eval_done);
    end
  endtask

  task automatic test_mid_insert;
    logic [7:0] exp_mem [3];
    int         n;
    exp_mem[0] = OP_1;
    exp_mem[1] = OP_MUL;
    exp_mem[2] = OP_2;
    apply_reset;
    do_insert(OP_1);
    do_insert(OP_2);
    press_left;
    checks++;
    if (cursor !== 6'd1) begin
      errors++;
      $display("FAIL mid_cursor_left cursor=%0d, required 1", cursor);
    end
    dataIn = OP_MUL;
    insert = 1'b1;
    tick;
    insert = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick;
    end
    checks++;
    if (n != 2 || size !== 6'd3 || cursor !== 6'd2) begin
      errors++;
      $display("FAIL mid_insert busy_cycles=%0d size=%0d cursor=%0d, required 2 3 2", n, size, cursor);
    end
    for (int a = 0; a < 3; a++) begin
      disp_addr = 5'(a);
      tick;
      checks++;
      if (disp_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL mid_mem%0d disp=%02h, required %02h", a, disp_data, exp_mem[a]);
      end
    end
  endtask

  task automatic test_delete;
    apply_reset;
    do_insert(OP_1);
    do_insert(OP_MUL);
    do_insert(OP_2);
    press_left;
    press_del;
    checks++;
    if (size !== 6'd2 || cursor !== 6'd1) begin
      errors++;
      $display("FAIL del_counts size=%0d cursor=%0d, required 2 1", size, cursor);
    end
    disp_addr = 5'd1;
    tick;
    checks++;
    if (disp_data !== OP_2) begin
      errors++;
      $display("FAIL del_mem1 disp=%02h, required %02h", disp_data, OP_2);
    end
  endtask

  task automatic test_held_insert;
    apply_reset;
    dataIn = OP_5;
    insert = 1'b1;
    repeat (10) tick;
    insert = 1'b0;
    tick;
    wait_idle;
    checks++;
    if (size !== 6'd1 || cursor !== 6'd1) begin
      errors++;
      $display("FAIL held_insert size=%0d cursor=%0d, required 1 1", size, cursor);
    end
    press_right;
    checks++;
    if (cursor !== 6'd1) begin
      errors++;
      $display("FAIL right_saturate cursor=%0d, required 1", cursor);
    end
    press_left;
    press_left;
    checks++;
    if (cursor !== 6'd0) begin
      errors++;
      $display("FAIL left_saturate cursor=%0d, required 0", cursor);
    end
    press_del;
    checks++;
    if (size !== 6'd1 || cursor !== 6'd0) begin
      errors++;
      $display("FAIL del_at_zero size=%0d cursor=%0d, required 1 0", size, cursor);
    end
  endtask

  task automatic test_full;
    apply_reset;
    for (int i = 0; i < depth; i++) do_insert(8'(8'h20 + i));
    checks++;
    if (size !== 6'd32 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill size=%0d full=%0b, required 32 1", size, full);
    end
    dataIn   = 8'hEE;
    insert   = 1'b1;
    ptrLeft  = 1'b1;
    tick;
    insert   = 1'b0;
    ptrLeft  = 1'b0;
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pulse ovf=%0b busy=%0b, required 1 0", overflow, busy);
    end
    tick;
    checks++;
    if (overflow !== 1'b0 || size !== 6'd32 || cursor !== 6'd32) begin
      errors++;
      $display("FAIL overflow_after ovf=%0b size=%0d cursor=%0d, required 0 32 32", overflow, size, cursor);
    end
    apply_reset;
    do_insert(OP_7);
    dataIn  = OP_8;
    insert  = 1'b1;
    ptrLeft = 1'b1;
    tick;
    insert  = 1'b0;
    ptrLeft = 1'b0;
    tick;
    wait_idle;
    checks++;
    if (size !== 6'd2 || cursor !== 6'd2) begin
      errors++;
      $display("FAIL insert_priority size=%0d cursor=%0d, required 2 2", size, cursor);
    end
  endtask

  task automatic test_stall_stream;
    logic [7:0] exp_tok [3];
    exp_tok[0] = OP_3;
    exp_tok[1] = OP_SIN;
    exp_tok[2] = OP_PI;
    apply_reset;
    eval = 1'b1;
    tick;
    eval = 1'b0;
    checks++;
    if (eval_done !== 1'b1 || tok_if.tok_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_eval done=%0b valid=%0b busy=%0b, required 1 0 0", eval_done, tok_if.tok_valid, busy);
    end
    tick;
    for (int i = 0; i < 3; i++) do_insert(exp_tok[i]);
    tok_if.tok_ready = 1'b0;
    eval = 1'b1;
    tick;
    eval = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (tok_if.tok_valid !== 1'b1 || tok_if.tok_data !== exp_tok[i]) begin
          errors++;
          $display("FAIL stall_tok%0d_wait%0d valid=%0b data=%02h, required 1 %02h", i, k, tok_if.tok_valid, tok_if.tok_data, exp_tok[i]);
        end
        tick;
      end
      tok_if.tok_ready = 1'b1;
      checks++;
      if (tok_if.tok_data !== exp_tok[i]) begin
        errors++;
        $display("FAIL stall_tok%0d_accept data=%02h, required %02h", i, tok_if.tok_data, exp_tok[i]);
      end
      tick;
      tok_if.tok_ready = 1'b0;
    end
    checks++;
    if (eval_done !== 1'b1 || size !== (clr ? 6'd0 : 6'd3)) begin
      errors++;
      $display("FAIL stall_done done=%0b size=%0d, required 1 %0d", eval_done, size, clr ? 0 : 3);
    end
    tok_if.tok_ready = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid_shift;
    logic [7:0] exp_mem [4];
    logic [4:0] addr [4];
    addr[0] = 5'd8;  exp_mem[0] = 8'h17;
    addr[1] = 5'd7;  exp_mem[1] = 8'h17;
    addr[2] = 5'd6;  exp_mem[2] = 8'h16;
    addr[3] = 5'd0;  exp_mem[3] = 8'h10;
    apply_reset;
    for (int i = 0; i < 8; i++) do_insert(8'(8'h10 + i));
    for (int i = 0; i < 8; i++) press_left;
    dataIn = 8'h99;
    insert = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || size !== 6'd0 || cursor !== 6'd0) begin
      errors++;
      $display("FAIL async_reset busy=%0b size=%0d cursor=%0d, required 0 0 0", busy, size, cursor);
    end
    repeat (2) tick;
    reset = 1'b1;
    repeat (3) tick;
    checks++;
    if (size !== 6'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_through_reset size=%0d busy=%0b, required 0 0", size, busy);
    end
    insert = 1'b0;
    tick;
    for (int j = 0; j < 4; j++) begin
      disp_addr = addr[j];
      tick;
      checks++;
      if (disp_data !== exp_mem[j]) begin
        errors++;
        $display("FAIL abort_mem%0d disp=%02h, required %02h", addr[j], disp_data, exp_mem[j]);
      end
    end
  endtask

  initial begin
    tok_if.tok_ready = 1'b1;
    test_reset;
    test_insert_stream;
    test_mid_insert;
    test_delete;
    test_held_insert;
    test_full;
    test_stall_stream;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/expr_buffer.md
EXPR_BUFFER -- requirements
Module: expr_buffer

Interface
REQ-001 SHALL have parameter width, default 8, token code width.
REQ-002 SHALL have parameter depth, default 32, maximum stored tokens; power of two.
REQ-003 SHALL have the following ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low.
- dataIn  in  width  token code from keyboard; sampled on an insert rising edge.
- insert, del, ptrLeft, ptrRight, eval  in  1 each  level-held keyboard controls.
- tok_data  out  width  streamed token during eval.
- tok_valid  out  1  tok_data valid.
- tok_ready  in  1  evaluator accepts the token.
- tok_last  out  1  high with the final streamed token.
- eval_done  out  1  one-cycle pulse when the stream ends.
- disp_addr  in  log2(depth)  display read index.
- disp_data  out  width  mem[disp_addr], registered, one-cycle latency.
- size  out  log2(depth)+1  stored token count.
- cursor  out  log2(depth)+1  insertion point, 0..size.
- busy  out  1  high in any non-IDLE state.
- full  out  1  size == depth.
- overflow  out  1  one-cycle pulse when an insert is dropped because the buffer is full.

Function
REQ-004 SHALL act on the rising edge only of each control input; a held level SHALL produce exactly one action.
REQ-005 SHALL resolve simultaneous edges by priority insert > del > ptrLeft > ptrRight > eval; lower-priority edges in that cycle SHALL be discarded.
REQ-006 SHALL discard edges arriving while busy, while still updating edge history.
REQ-007 SHALL implement FSM states IDLE, INS_SHIFT, DEL_SHIFT, STREAM.
REQ-008 Insert edge in IDLE, not full: latch dataIn, enter INS_SHIFT, move mem[i-1] to mem[i] one entry per cycle for i = size down to cursor+1, then write mem[cursor], increment size and cursor, return to IDLE. Total size-cursor+1 cycles.
REQ-009 Insert edge when full: no state change; pulse overflow.
REQ-010 Del edge with cursor > 0: enter DEL_SHIFT, move mem[i+1] to mem[i] one entry per cycle for i = cursor-1 to size-2, then decrement size and cursor; return to IDLE.
REQ-011 Del edge with cursor == 0: no-op.
REQ-012 ptrLeft SHALL decrement cursor, saturating at 0; ptrRight SHALL increment cursor, saturating at size; each takes 1 cycle and stays in IDLE.
REQ-013 Eval edge with size > 0: enter STREAM, present mem[0..size-1] in order on tok_data with tok_valid; advance only on tok_valid && tok_ready; tok_last with index size-1.
REQ-014 tok_data SHALL be held stable while tok_valid && !tok_ready.
REQ-015 The final handshake SHALL pulse eval_done in the next cycle and return to IDLE.
REQ-016 Eval edge with size == 0: pulse eval_done in the next cycle; tok_valid stays low.
REQ-017 disp_data SHALL reflect memory contents as of the previous cycle, including during shifts.

Reset
REQ-018 reset low SHALL asynchronously clear state to IDLE, size, cursor, tok_valid, tok_last, eval_done, overflow, disp_data and edge history to 0.
REQ-019 Memory contents SHALL be don't-care after reset.
REQ-020 Reset mid-shift or mid-stream SHALL abort with no further memory writes.
REQ-021 A control held through reset release SHALL not act; edge history is cleared and the first sampled cycle records the level.

Configuration
REQ-022 With EXPR_BUFFER_CLEAR_ON_EVAL_EN defined, the cycle that pulses eval_done SHALL also set size and cursor to 0.
REQ-023 Without EXPR_BUFFER_CLEAR_ON_EVAL_EN, size, cursor and contents SHALL be unchanged by eval.

Structure
REQ-024 Token codes OP_0..OP_9, OP_ADD..OP_TAN, OP_DECIMAL, OP_E, OP_PI and FSM state encoding SHALL live in shared package calc_pkg.
REQ-025 The rising-edge detector SHALL be sub-module edge_detect, instantiated once per control input.

Verification
REQ-026 Insert 0x01, 0x0A, 0x02 -> size=3, cursor=3, stream yields 01,0A,02, tok_last on 02.
REQ-027 Cursor at 1 of [01,02]; insert 0x0C -> [01,0C,02], busy for 2 cycles, cursor=2.
REQ-028 Insert held 10 cycles -> exactly one token stored; del at cursor=0 -> no change.
REQ-029 Fill 32 tokens, insert again -> overflow pulse, size stays 32; insert and ptrLeft same edge -> only the insert occurs.
REQ-030 Stream with tok_ready low 3 cycles per token -> tok_data stable, no token lost; eval_done pulse; size per macro setting.
REQ-031 Assert reset mid-INS_SHIFT -> IDLE, size=0, no further writes.
